// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e       : controller FSM state encoding (RUN / MEMWAIT / FAULT)
//   - FWD_RF/W/M    : ALU operand source select codes
//   - TIMEOUT_DEF   : default maximum number of MEMWAIT cycles
//   - fwd_select()  : forwarding priority rule shared by both ALU operands
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_FAULT   = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int TIMEOUT_DEF = 255;

    // The wait counter is 16 bits wide, so TIMEOUT must stay below 65536.
    localparam int WAIT_CNT_W  = 16;
    localparam int STALL_CNT_W = 16;

    // Register 0 is hard-wired to zero and is never a forwarding/hazard source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // The youngest writer (MEM) wins over the older one (WB).
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       regwr_m,
        input logic [4:0] wreg_m,
        input logic       regwr_w,
        input logic [4:0] wreg_w
    );
        logic [1:0] sel;
        if (regwr_m && (wreg_m != REG_ZERO) && (wreg_m == src)) begin
            sel = FWD_M;
        end else if (regwr_w && (wreg_w != REG_ZERO) && (wreg_w == src)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational register-dependency checks for the pipeline.
// Ports:
//   rs_d_i, rt_d_i, use_rt_d_i        : decode-stage sources (Rt only if used)
//   rs_e_i, rt_e_i                    : execute-stage sources
//   regwr_e_i, memtoreg_e_i, wreg_e_i : execute-stage writer (load if memtoreg)
//   regwr_m_i, wreg_m_i               : memory-stage writer
//   regwr_w_i, wreg_w_i               : writeback-stage writer
//   load_use_o                        : decode needs a value still being loaded
//   fwd_a_o, fwd_b_o                  : ALU operand source selects (Rs / Rt)
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       use_rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic       regwr_e_i,
    input  logic       memtoreg_e_i,
    input  logic [4:0] wreg_e_i,
    input  logic       regwr_m_i,
    input  logic [4:0] wreg_m_i,
    input  logic       regwr_w_i,
    input  logic [4:0] wreg_w_i,
    output logic       load_use_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    logic rs_match_s;
    logic rt_match_s;

    // Load-use: a load in EX writes a register the decode instruction reads.
    always_comb begin
        rs_match_s = (wreg_e_i == rs_d_i);
        rt_match_s = use_rt_d_i && (wreg_e_i == rt_d_i);
        if (memtoreg_e_i && regwr_e_i && (wreg_e_i != REG_ZERO) &&
            (rs_match_s || rt_match_s)) begin
            load_use_o = 1'b1;
        end else begin
            load_use_o = 1'b0;
        end
    end

    // Operand forwarding selects for both ALU inputs.
    always_comb begin
        fwd_a_o = fwd_select(rs_e_i, regwr_m_i, wreg_m_i, regwr_w_i, wreg_w_i);
        fwd_b_o = fwd_select(rt_e_i, regwr_m_i, wreg_m_i, regwr_w_i, wreg_w_i);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Stall / flush / forwarding controller for a 5-stage pipeline.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   Rs_D, Rt_D, UseRt_D           : decode-stage sources
//   Rs_E, Rt_E                    : execute-stage sources
//   RegWr_E, MemtoReg_E, WriteReg_E : execute-stage writer
//   RegWr_M, WriteReg_M           : memory-stage writer
//   RegWr_W, WriteReg_W           : writeback-stage writer
//   br_taken_M                    : branch/jump resolved taken in MEM
//   mem_req_M, mem_ack            : data-memory access and its completion
//   stall_F/D/E/M                 : hold PC, IF_ID, ID_EX, EX_MEM
//   flush_D/E/M/W                 : bubble into IF_ID, ID_EX, EX_MEM, MEM_WB
//   fwdA_E, fwdB_E                : ALU operand source selects
//   fault                         : sticky memory timeout
//   stall_cycles                  : saturating count of cycles with stall_F
// Stall/flush outputs depend on the current-cycle mem_ack/br_taken_M, so they
// are decoded combinationally from the registered state.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             Rs_D,
    input  logic [4:0]             Rt_D,
    input  logic                   UseRt_D,
    input  logic [4:0]             Rs_E,
    input  logic [4:0]             Rt_E,
    input  logic                   RegWr_E,
    input  logic                   MemtoReg_E,
    input  logic [4:0]             WriteReg_E,
    input  logic                   RegWr_M,
    input  logic [4:0]             WriteReg_M,
    input  logic                   RegWr_W,
    input  logic [4:0]             WriteReg_W,
    input  logic                   br_taken_M,
    input  logic                   mem_req_M,
    input  logic                   mem_ack,
    output logic                   stall_F,
    output logic                   stall_D,
    output logic                   stall_E,
    output logic                   stall_M,
    output logic                   flush_D,
    output logic                   flush_E,
    output logic                   flush_M,
    output logic                   flush_W,
    output logic [1:0]             fwdA_E,
    output logic [1:0]             fwdB_E,
    output logic                   fault,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    state_e                 state_q;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q;
    logic                   fault_q;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    logic       load_use_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       mem_hold_s;
    logic       branch_s;
    logic       lu_stall_s;
    logic       stall_f_s;

    hazard_detect u_hazard (
        .rs_d_i       (Rs_D),
        .rt_d_i       (Rt_D),
        .use_rt_d_i   (UseRt_D),
        .rs_e_i       (Rs_E),
        .rt_e_i       (Rt_E),
        .regwr_e_i    (RegWr_E),
        .memtoreg_e_i (MemtoReg_E),
        .wreg_e_i     (WriteReg_E),
        .regwr_m_i    (RegWr_M),
        .wreg_m_i     (WriteReg_M),
        .regwr_w_i    (RegWr_W),
        .wreg_w_i     (WriteReg_W),
        .load_use_o   (load_use_s),
        .fwd_a_o      (fwd_a_s),
        .fwd_b_o      (fwd_b_s)
    );

    // Memory hold: an unacknowledged access, or the terminal FAULT state.
    // The ack cycle itself is not held, so anything waiting behind the
    // memory access (e.g. a taken branch) takes effect in that cycle.
    always_comb begin
        case (state_q)
            ST_RUN: begin
                if (mem_req_M && !mem_ack) begin
                    mem_hold_s = 1'b1;
                end else begin
                    mem_hold_s = 1'b0;
                end
            end
            ST_MEMWAIT: begin
                if (!mem_ack) begin
                    mem_hold_s = 1'b1;
                end else begin
                    mem_hold_s = 1'b0;
                end
            end
            ST_FAULT: mem_hold_s = 1'b1;
            default:  mem_hold_s = 1'b1;
        endcase
    end

    // Hazard priority: memory hold > taken branch > load-use.
    always_comb begin
        if (mem_hold_s) begin
            branch_s   = 1'b0;
            lu_stall_s = 1'b0;
        end else if (br_taken_M) begin
            branch_s   = 1'b1;
            lu_stall_s = 1'b0;
        end else begin
            branch_s   = 1'b0;
            lu_stall_s = load_use_s;
        end
        stall_f_s = mem_hold_s | lu_stall_s;
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        if (rst) begin
            stall_F = 1'b0;
            stall_D = 1'b0;
            stall_E = 1'b0;
            stall_M = 1'b0;
            flush_D = 1'b0;
            flush_E = 1'b0;
            flush_M = 1'b0;
            flush_W = 1'b0;
            fwdA_E  = FWD_RF;
            fwdB_E  = FWD_RF;
        end else begin
            stall_F = stall_f_s;
            stall_D = mem_hold_s | lu_stall_s;
            stall_E = mem_hold_s;
            stall_M = mem_hold_s;
            flush_D = branch_s;
            flush_E = branch_s | lu_stall_s;
            flush_M = branch_s;
            flush_W = mem_hold_s;
            fwdA_E  = fwd_a_s;
            fwdB_E  = fwd_b_s;
        end
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        if (stall_f_s && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Controller FSM, memory wait counter, sticky fault and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            fault_q        <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            case (state_q)
                ST_RUN: begin
                    if (mem_req_M && !mem_ack) begin
                        state_q    <= ST_MEMWAIT;
                        wait_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_RUN;
                    end
                end
                ST_MEMWAIT: begin
                    if (mem_ack) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == TIMEOUT_C) begin
                        // TIMEOUT+1 MEMWAIT cycles have elapsed.
                        state_q    <= ST_FAULT;
                        fault_q    <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
                default: begin
                    // Corrupted state encoding is treated as a fault.
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign fault        = fault_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed, table-driven bench for pipe_ctrl plus hand-written sequences for
// memory wait, timeout/fault, simultaneous events and mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic        UseRt_D, RegWr_E, MemtoReg_E, RegWr_M, RegWr_W;
    logic        br_taken_M, mem_req_M, mem_ack;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_M, flush_W;
    logic [1:0]  fwdA_E, fwdB_E;
    logic        fault;
    logic [15:0] stall_cycles;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .UseRt_D(UseRt_D),
        .Rs_E(Rs_E), .Rt_E(Rt_E),
        .RegWr_E(RegWr_E), .MemtoReg_E(MemtoReg_E), .WriteReg_E(WriteReg_E),
        .RegWr_M(RegWr_M), .WriteReg_M(WriteReg_M),
        .RegWr_W(RegWr_W), .WriteReg_W(WriteReg_W),
        .br_taken_M(br_taken_M), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .fault(fault), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs_d, rt_d;
        logic       use_rt;
        logic [4:0] rs_e, rt_e;
        logic       regwr_e, m2r_e;
        logic [4:0] wr_e;
        logic       regwr_m;
        logic [4:0] wr_m;
        logic       regwr_w;
        logic [4:0] wr_w;
        logic       br, req, ack;
        logic [3:0] exp_stall;   // {F,D,E,M}
        logic [3:0] exp_flush;   // {D,E,M,W}
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mkv(
        input logic [4:0] rs_d, input logic [4:0] rt_d, input logic use_rt,
        input logic [4:0] rs_e, input logic [4:0] rt_e,
        input logic regwr_e, input logic m2r_e, input logic [4:0] wr_e,
        input logic regwr_m, input logic [4:0] wr_m,
        input logic regwr_w, input logic [4:0] wr_w,
        input logic br, input logic req, input logic ack,
        input logic [3:0] es, input logic [3:0] ef,
        input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.rs_d = rs_d; v.rt_d = rt_d; v.use_rt = use_rt;
        v.rs_e = rs_e; v.rt_e = rt_e;
        v.regwr_e = regwr_e; v.m2r_e = m2r_e; v.wr_e = wr_e;
        v.regwr_m = regwr_m; v.wr_m = wr_m;
        v.regwr_w = regwr_w; v.wr_w = wr_w;
        v.br = br; v.req = req; v.ack = ack;
        v.exp_stall = es; v.exp_flush = ef; v.exp_fa = fa; v.exp_fb = fb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic set_idle();
        Rs_D = 5'd0; Rt_D = 5'd0; UseRt_D = 1'b0; Rs_E = 5'd0; Rt_E = 5'd0;
        RegWr_E = 1'b0; MemtoReg_E = 1'b0; WriteReg_E = 5'd0;
        RegWr_M = 1'b0; WriteReg_M = 5'd0; RegWr_W = 1'b0; WriteReg_W = 5'd0;
        br_taken_M = 1'b0; mem_req_M = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_load_use();
        MemtoReg_E = 1'b1; RegWr_E = 1'b1; WriteReg_E = 5'd5; Rs_D = 5'd5;
    endtask

    task automatic apply_vec(input vec_t v);
        Rs_D = v.rs_d; Rt_D = v.rt_d; UseRt_D = v.use_rt; Rs_E = v.rs_e; Rt_E = v.rt_e;
        RegWr_E = v.regwr_e; MemtoReg_E = v.m2r_e; WriteReg_E = v.wr_e;
        RegWr_M = v.regwr_m; WriteReg_M = v.wr_m; RegWr_W = v.regwr_w; WriteReg_W = v.wr_w;
        br_taken_M = v.br; mem_req_M = v.req; mem_ack = v.ack;
    endtask

    function automatic logic [7:0] sf();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};
    endfunction

    function automatic logic [12:0] all_outs();
        return {sf(), fwdA_E, fwdB_E, fault};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        #2;
        chk("rst_outs", 32'(all_outs()), 32'd0);
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        int first_fault;

        vecs[0]  = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[1]  = mkv(5'd5,5'd0,1'b0, 5'd0,5'd0, 1'b1,1'b1,5'd5, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b1100,4'b0100,2'b00,2'b00);
        vecs[2]  = mkv(5'd1,5'd7,1'b1, 5'd0,5'd0, 1'b1,1'b1,5'd7, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b1100,4'b0100,2'b00,2'b00);
        vecs[3]  = mkv(5'd1,5'd7,1'b0, 5'd0,5'd0, 1'b1,1'b1,5'd7, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[4]  = mkv(5'd0,5'd0,1'b1, 5'd0,5'd0, 1'b1,1'b1,5'd0, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[5]  = mkv(5'd5,5'd0,1'b0, 5'd0,5'd0, 1'b1,1'b0,5'd5, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[6]  = mkv(5'd0,5'd0,1'b0, 5'd3,5'd0, 1'b0,1'b0,5'd0, 1'b1,5'd3,1'b1,5'd3, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b10,2'b00);
        vecs[7]  = mkv(5'd0,5'd0,1'b0, 5'd3,5'd0, 1'b0,1'b0,5'd0, 1'b1,5'd0,1'b1,5'd3, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b01,2'b00);
        vecs[8]  = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b1,5'd3,1'b1,5'd3, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[9]  = mkv(5'd0,5'd0,1'b0, 5'd9,5'd4, 1'b0,1'b0,5'd0, 1'b1,5'd4,1'b0,5'd4, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b10);
        vecs[10] = mkv(5'd0,5'd0,1'b0, 5'd4,5'd4, 1'b0,1'b0,5'd0, 1'b0,5'd4,1'b1,5'd4, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b01,2'b01);
        vecs[11] = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b0,5'd0,1'b0,5'd0, 1'b1,1'b0,1'b0, 4'b0000,4'b1110,2'b00,2'b00);
        vecs[12] = mkv(5'd5,5'd0,1'b0, 5'd0,5'd0, 1'b1,1'b1,5'd5, 1'b0,5'd0,1'b0,5'd0, 1'b1,1'b0,1'b0, 4'b0000,4'b1110,2'b00,2'b00);
        vecs[13] = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b0,5'd0,1'b0,5'd0, 1'b0,1'b1,1'b1, 4'b0000,4'b0000,2'b00,2'b00);
        vecs[14] = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b0,5'd0,1'b0,5'd0, 1'b1,1'b1,1'b1, 4'b0000,4'b1110,2'b00,2'b00);
        vecs[15] = mkv(5'd0,5'd0,1'b0, 5'd6,5'd8, 1'b0,1'b0,5'd0, 1'b1,5'd6,1'b1,5'd8, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b10,2'b01);
        vecs[16] = mkv(5'd0,5'd0,1'b0, 5'd0,5'd0, 1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1,5'd0, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,2'b00,2'b00);

        // ---------------- table: combinational behaviour in RUN ----------------
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < NVEC; i++) begin
            tick();
            apply_vec(vecs[i]);
            #2;
            chk($sformatf("vec%0d_stall", i), 32'({stall_F, stall_D, stall_E, stall_M}), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_flush", i), 32'({flush_D, flush_E, flush_M, flush_W}), 32'(vecs[i].exp_flush));
            chk($sformatf("vec%0d_fwdA", i), 32'(fwdA_E), 32'(vecs[i].exp_fa));
            chk($sformatf("vec%0d_fwdB", i), 32'(fwdB_E), 32'(vecs[i].exp_fb));
            if (vecs[i].exp_stall[3]) exp_cnt++;
        end
        tick();
        set_idle();
        #2;
        chk("table_stall_cycles", 32'(stall_cycles), 32'(exp_cnt));

        // ---------------- load-use lasts one cycle, counter = 1 ----------------
        do_reset();
        tick();
        set_load_use();
        #2;
        chk("lu_outs", 32'(sf()), 32'b1100_0100);
        tick();
        set_idle();
        #2;
        chk("lu_release", 32'(sf()), 32'd0);
        chk("lu_cnt", 32'(stall_cycles), 32'd1);

        // ---------------- memory wait, ack after 4 cycles ----------------
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            mem_req_M = 1'b1; mem_ack = 1'b0;
            #2;
            chk($sformatf("memwait_c%0d", c), 32'(sf()), 32'b1111_0001);
        end
        tick();
        mem_ack = 1'b1;
        #2;
        chk("memwait_ack", 32'(sf()), 32'd0);
        tick();
        set_idle();
        #2;
        chk("memwait_back_run", 32'(sf()), 32'd0);
        chk("memwait_cnt", 32'(stall_cycles), 32'd4);

        // ---------------- branch (and load-use) held by memory wait ----------------
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            set_idle();
            mem_req_M = 1'b1; br_taken_M = 1'b1;
            if (c == 1) set_load_use();
            #2;
            chk($sformatf("brwait_c%0d", c), 32'(sf()), 32'b1111_0001);
        end
        tick();
        set_idle();
        mem_req_M = 1'b1; mem_ack = 1'b1; br_taken_M = 1'b1;
        #2;
        chk("brwait_ack", 32'(sf()), 32'b0000_1110);
        tick();
        set_idle();
        #2;
        chk("brwait_after", 32'(sf()), 32'd0);

        // ---------------- timeout into FAULT ----------------
        do_reset();
        tick();
        mem_req_M = 1'b1; mem_ack = 1'b0;
        #2;
        chk("to_first", 32'(sf()), 32'b1111_0001);
        first_fault = -1;
        for (int k = 1; k < 400; k++) begin
            tick();
            #2;
            if (fault === 1'b1) begin
                first_fault = k;
                break;
            end
        end
        // cycle 0 is RUN, cycles 1..TIMEOUT+1 are MEMWAIT, FAULT follows.
        chk("to_fault_cycle", 32'(first_fault), 32'(TIMEOUT + 2));
        for (int c = 0; c < 3; c++) begin
            tick();
            set_idle();
            mem_ack = 1'b1; br_taken_M = 1'b1;
            #2;
            chk($sformatf("fault_sticky_c%0d", c), 32'({fault, sf()}), 32'b1_1111_0001);
        end
        // Asynchronous reset in FAULT, between clock edges.
        tick();
        mem_req_M = 1'b1; mem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("fault_rst_outs", 32'(all_outs()), 32'd0);
        chk("fault_rst_cnt", 32'(stall_cycles), 32'd0);
        set_idle();
        rst = 1'b0;
        #1;
        chk("fault_rst_run", 32'({fault, sf()}), 32'd0);

        // ---------------- asynchronous reset mid-MEMWAIT ----------------
        do_reset();
        tick();
        mem_req_M = 1'b1; mem_ack = 1'b0;
        #2;
        chk("mwrst_stalled", 32'(sf()), 32'b1111_0001);
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("mwrst_outs", 32'(all_outs()), 32'd0);
        chk("mwrst_cnt", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        set_idle();
        #1;
        // With ack low, a surviving MEMWAIT state would still stall here.
        chk("mwrst_run", 32'(sf()), 32'd0);
        tick();
        #2;
        chk("mwrst_next", 32'(sf()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
